// File: rtl/hazard_tracker.sv
// ============================================================================
//  Module      : hazard_tracker
//  Description : Tuse/Tnew hazard unit for a 5-stage MIPS pipeline: ID stall,
//                E-stage bubble injection, operand forwarding selects and
//                mult/div busy tracking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_tracker #(
    parameter int TW     = 2,
    parameter int AW     = 5,
    parameter int MD_LAT = 5,
    parameter int MD_CW  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [AW-1:0] id_waddr,
    input  logic [TW-1:0] id_tnew,
    input  logic          id_md_use,
    input  logic          md_start,
    output logic          stall,
    output logic          md_busy,
    output logic [1:0]    fwd_rs,
    output logic [1:0]    fwd_rt
);

    localparam logic [MD_CW-1:0] c_md_lat = MD_CW'(MD_LAT);

    logic [AW-1:0]    r_e_waddr, r_m_waddr, r_w_waddr;
    logic [TW-1:0]    r_e_tnew,  r_m_tnew,  r_w_tnew;
    logic [MD_CW-1:0] r_md_cnt;

    logic             w_rs_hazard, w_rt_hazard;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        return (x == '0) ? '0 : x - TW'(1);
    endfunction

    // Youngest matching slot decides; an older match behind it is never consulted.
    function automatic logic src_hazard(input logic [AW-1:0] a,
                                        input logic          used,
                                        input logic [TW-1:0] tuse);
        logic h;
        h = 1'b0;
        if (used && (a != '0)) begin
            if (r_e_waddr == a)
                h = (r_e_tnew > tuse);
            else if (r_m_waddr == a)
                h = (r_m_tnew > tuse);
            else if (r_w_waddr == a)
                h = (r_w_tnew > tuse);
        end
        return h;
    endfunction

    function automatic logic [1:0] src_fwd(input logic [AW-1:0] a);
        logic [1:0] f;
        f = 2'd0;
        if (a != '0) begin
            if (r_e_waddr == a)
                f = (r_e_tnew == '0) ? 2'd1 : 2'd0;
            else if (r_m_waddr == a)
                f = (r_m_tnew == '0) ? 2'd2 : 2'd0;
            else if (r_w_waddr == a)
                f = (r_w_tnew == '0) ? 2'd3 : 2'd0;
        end
        return f;
    endfunction

    assign w_rs_hazard = src_hazard(id_rs, id_rs_used, id_tuse_rs);
    assign w_rt_hazard = src_hazard(id_rt, id_rt_used, id_tuse_rt);

    assign md_busy = (r_md_cnt != '0) | md_start;
    assign stall   = w_rs_hazard | w_rt_hazard | (id_md_use & md_busy);
    assign fwd_rs  = src_fwd(id_rs);
    assign fwd_rt  = src_fwd(id_rt);

    // Slots always advance; a stall only turns the entering E slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_waddr <= '0;
            r_e_tnew  <= '0;
            r_m_waddr <= '0;
            r_m_tnew  <= '0;
            r_w_waddr <= '0;
            r_w_tnew  <= '0;
        end else begin
            r_e_waddr <= stall ? '0 : id_waddr;
            r_e_tnew  <= stall ? '0 : id_tnew;
            r_m_waddr <= r_e_waddr;
            r_m_tnew  <= sat_dec(r_e_tnew);
            r_w_waddr <= r_m_waddr;
            r_w_tnew  <= sat_dec(r_m_tnew);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_md_cnt <= '0;
        else if (md_start)
            r_md_cnt <= c_md_lat;
        else if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - MD_CW'(1);
    end

endmodule

`default_nettype wire
